// File: rtl/chunk_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// chunk_serial_adder_pkg
//   Shared definitions for the chunk-serial adder/subtractor:
//   - state_t : controller states
//   - clog2   : ceiling log2 used to size the chunk counter
//   - cfg_ok  : legality of a WIDTH/CHUNK pair, checked at elaboration
// -----------------------------------------------------------------------------
package chunk_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_serial_adder_fa_chunk.sv
// -----------------------------------------------------------------------------
// fa_chunk
//   Combinational CHUNK-bit ripple of propagate/generate full-adder cells.
//   Ports:
//     a, b   in  CHUNK  operand slices
//     cin    in  1      carry into bit 0
//     s      out CHUNK  slice sum
//     cout   out 1      carry out of the top cell
//     c_msb  out 1      carry into the top cell (used for signed overflow)
// -----------------------------------------------------------------------------
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic c_run;
  logic p;
  logic g;

  always_comb begin
    s     = '0;
    c_msb = 1'b0;
    c_run = cin;
    p     = 1'b0;
    g     = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      p    = a[i] ^ b[i];
      g    = a[i] & b[i];
      s[i] = p ^ c_run;
      if (i == CHUNK - 1) begin
        c_msb = c_run;
      end
      c_run = g | (p & c_run);
    end
    cout = c_run;
  end

endmodule

// File: rtl/chunk_serial_adder.sv
// -----------------------------------------------------------------------------
// chunk_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, with a carry
//   flop between chunks. Latency WIDTH/CHUNK cycles, start/busy/done handshake.
//   Ports:
//     clk    in   1      clock, rising edge
//     rst    in   1      synchronous active-high reset
//     start  in   1      request, honoured only while not busy
//     sub    in   1      0: a+b+cin, 1: a-b
//     a, b   in   WIDTH  operands, captured on accepted start
//     cin    in   1      carry-in for add
//     busy   out  1      operation in progress
//     done   out  1      one-cycle pulse when results update
//     sum    out  WIDTH  result, held until next completion
//     cout   out  1      carry out of MSB (sub: 1 = no borrow)
//     ovf    out  1      signed overflow
// -----------------------------------------------------------------------------
module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (clog2(NCH) < 1) ? 1 : clog2(NCH);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK, CHUNK >= 1");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] ch_s;
  logic             ch_cout;
  logic             ch_cmsb;
  logic [WIDTH-1:0] psum_next;
  logic             last_chunk;

  fa_chunk #(.CHUNK(CHUNK)) u_fa (
    .a     (a_sh_q[CHUNK-1:0]),
    .b     (b_sh_q[CHUNK-1:0]),
    .cin   (carry_q),
    .s     (ch_s),
    .cout  (ch_cout),
    .c_msb (ch_cmsb)
  );

  // New chunk enters at the top; after NCH chunks the LSB chunk sits at bit 0.
  assign psum_next  = (psum_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
  assign last_chunk = (cnt_q == CW'(NCH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_sh_d  = a;
          b_sh_d  = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          psum_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        carry_d = ch_cout;
        psum_d  = psum_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = psum_next;
          cout_d  = ch_cout;
          ovf_d   = ch_cout ^ ch_cmsb;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_chunk_serial_adder
//   Three instances (CHUNK = 4, 1, 16; WIDTH = 16) each with an arithmetic
//   reference model checked every cycle, plus directed literal expectations.
// -----------------------------------------------------------------------------
module tb_chunk_serial_adder;

  localparam int W  = 16;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_i[ND];
  logic         sub_i[ND];
  logic         cin_i[ND];
  logic [W-1:0] a_i[ND];
  logic [W-1:0] b_i[ND];
  logic         busy_o[ND];
  logic         done_o[ND];
  logic         cout_o[ND];
  logic         ovf_o[ND];
  logic [W-1:0] sum_o[ND];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .start(start_i[0]), .sub(sub_i[0]), .a(a_i[0]), .b(b_i[0]),
    .cin(cin_i[0]), .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]),
    .cout(cout_o[0]), .ovf(ovf_o[0]));

  chunk_serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .sub(sub_i[1]), .a(a_i[1]), .b(b_i[1]),
    .cin(cin_i[1]), .busy(busy_o[1]), .done(done_o[1]), .sum(sum_o[1]),
    .cout(cout_o[1]), .ovf(ovf_o[1]));

  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .start(start_i[2]), .sub(sub_i[2]), .a(a_i[2]), .b(b_i[2]),
    .cin(cin_i[2]), .busy(busy_o[2]), .done(done_o[2]), .sum(sum_o[2]),
    .cout(cout_o[2]), .ovf(ovf_o[2]));

  function automatic int nch(input int idx);
    case (idx)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  // Reference result {ovf, cout, sum} from integer arithmetic.
  function automatic logic [W+1:0] ref_add(input logic s, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic c);
    int ua, ub, sa, sb, u, sr;
    logic [31:0] ut;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      u  = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + int'(c);
      sr = sa + sb + int'(c);
      co = (u > 65535);
    end
    ov = (sr > 32767) || (sr < -32768);
    ut = u;
    return {ov, co, ut[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           rem_m[ND];
  logic         busy_m[ND];
  logic         done_m[ND];
  logic [W+1:0] res_m[ND];
  logic [W+1:0] pend_m[ND];
  logic         model_live = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    model_live <= 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (rst) begin
        rem_m[i]  <= 0;
        busy_m[i] <= 1'b0;
        done_m[i] <= 1'b0;
        res_m[i]  <= '0;
        pend_m[i] <= '0;
      end else if (rem_m[i] > 0) begin
        rem_m[i]  <= rem_m[i] - 1;
        done_m[i] <= (rem_m[i] == 1);
        if (rem_m[i] == 1) begin
          res_m[i]  <= pend_m[i];
          busy_m[i] <= 1'b0;
        end
      end else begin
        done_m[i] <= 1'b0;
        if (start_i[i]) begin
          pend_m[i] <= ref_add(sub_i[i], a_i[i], b_i[i], cin_i[i]);
          rem_m[i]  <= nch(i);
          busy_m[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int i = 0; i < ND; i++) begin
        check($sformatf("cycle_cmp[%0d] {busy,done,ovf,cout,sum}", i),
              {12'd0, busy_o[i], done_o[i], ovf_o[i], cout_o[i], sum_o[i]},
              {12'd0, busy_m[i], done_m[i], res_m[i]});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } op_t;

  op_t ops[5];

  task automatic do_op(input int idx, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c, input int noise,
                       input bit lit, input logic [W-1:0] es, input logic ec,
                       input logic eo, output int done_cyc);
    int n;
    int bcnt;
    n    = 0;
    bcnt = 0;
    sub_i[idx]   = s;
    a_i[idx]     = a;
    b_i[idx]     = b;
    cin_i[idx]   = c;
    start_i[idx] = 1'b1;
    @(posedge clk); #1;
    start_i[idx] = 1'b0;
    while (!done_o[idx] && n < 64) begin
      if (busy_o[idx]) bcnt++;
      if (n < noise) begin
        start_i[idx] = 1'b1;
        sub_i[idx]   = 1'b0;
        a_i[idx]     = 16'hFFFF;
        b_i[idx]     = 16'hFFFF;
      end else begin
        start_i[idx] = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start_i[idx] = 1'b0;
    check($sformatf("latency[%0d]", idx), n, nch(idx));
    check($sformatf("busy_cycles[%0d]", idx), bcnt, nch(idx));
    if (lit) begin
      check($sformatf("result[%0d] {ovf,cout,sum}", idx),
            {14'd0, ovf_o[idx], cout_o[idx], sum_o[idx]}, {14'd0, eo, ec, es});
    end
    done_cyc = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, dn;
    ops[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    ops[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    ops[2] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    ops[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    ops[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    // Reset with start held high: must not be accepted.
    rst = 1'b1;
    for (int i = 0; i < ND; i++) begin
      start_i[i] = 1'b1;
      sub_i[i]   = 1'b0;
      cin_i[i]   = 1'b0;
      a_i[i]     = 16'h1234;
      b_i[i]     = 16'h4321;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      check($sformatf("reset_state[%0d]", i),
            {12'd0, busy_o[i], done_o[i], ovf_o[i], cout_o[i], sum_o[i]}, 32'd0);
      start_i[i] = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic on every chunk size.
    for (int i = 0; i < ND; i++) begin
      for (int k = 0; k < 5; k++) begin
        do_op(i, ops[k].s, ops[k].a, ops[k].b, ops[k].c, 0, 1'b1,
              ops[k].es, ops[k].ec, ops[k].eo, dn);
        @(posedge clk); #1;
      end
    end

    // Start pulses while busy are ignored.
    do_op(0, 1'b0, 16'h1111, 16'h2222, 1'b0, 2, 1'b1, 16'h3333, 1'b0, 1'b0, dn);
    @(posedge clk); #1;

    // Start in the done cycle: second done NCH+1 cycles after the first.
    do_op(0, 1'b0, 16'h0F0F, 16'h0101, 1'b1, 0, 1'b1, 16'h1011, 1'b0, 1'b0, d1);
    do_op(0, 1'b1, 16'h0003, 16'h0003, 1'b0, 0, 1'b1, 16'h0000, 1'b1, 1'b0, d2);
    check("back_to_back_spacing", d2 - d1, 5);
    @(posedge clk); #1;

    // Reset in the second RUN cycle aborts and clears the held result.
    sub_i[0] = 1'b0; a_i[0] = 16'h0102; b_i[0] = 16'h0304; cin_i[0] = 1'b0;
    start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int dcount;
      dcount = 0;
      repeat (8) begin
        @(posedge clk); #1;
        if (done_o[0]) dcount++;
      end
      check("abort_done_count", dcount, 0);
      check("abort_sum_cleared", {12'd0, busy_o[0], ovf_o[0], cout_o[0], sum_o[0]}, 32'd0);
    end

    // Random sweep; the per-cycle model does the result checking.
    for (int i = 0; i < ND; i++) begin
      int nops;
      nops = (i == 0) ? 1000 : 100;
      for (int k = 0; k < nops; k++) begin
        do_op(i, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 0, 1'b0, 16'h0, 1'b0, 1'b0, dn);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
